// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared opcode constants, FSM/class types and decode helpers for mc_sequencer
//   OP_*      : IR[31:27] opcodes of the supported subset
//   ALU_*     : IR[6:2] R-type function codes that need the multi-cycle ALU
//   state_t   : FETCH, DECODE, EXEC, MEM, WB
//   class_t   : instruction class latched in DECODE
package mc_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [2:0] {NOP, RTYPE, ADDI, SW, LW, ILLEGAL} class_t;

    function automatic class_t decode_class(input logic [4:0] op);
        return (op == OP_RTYPE) ? RTYPE :
               (op == OP_ADDI)  ? ADDI  :
               (op == OP_SW)    ? SW    :
               (op == OP_LW)    ? LW    : ILLEGAL;
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op, input logic [4:0] aop);
        return (op == OP_RTYPE) && ((aop == ALU_MULT) || (aop == ALU_DIV));
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive stalled cycles and flags when MAX_WAIT is reached
//   clock, resetn : clock and asynchronous active-low reset
//   clear         : zero the count (takes priority over enable)
//   enable        : count this cycle as a stall
//   expired       : count has reached MAX_WAIT
module mc_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(MAX_WAIT + 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(MAX_WAIT));

    // Saturates at MAX_WAIT so a missing clear can never wrap it back to zero
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
//   clock, resetn           : clock and asynchronous active-low reset
//   opcode, aluop           : instruction fields (IR[31:27], IR[6:2])
//   imem/dmem/alu_ready     : handshake inputs from memories and mult/div ALU
//   imem_req, ir_we, pc_we  : fetch-side strobes
//   alu_start               : one-cycle mult/div start in DECODE
//   dmem_re, dmem_we        : data memory strobes held through MEM
//   rf_we                   : register write in WB
//   ALUinB, Rdst, Rwd       : datapath mux selects from the latched class
//   illegal, timeout        : one-cycle event pulses
//   retired                 : completed-instruction count
module mc_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       opcode,
    input  logic [4:0]       aluop,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             alu_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             alu_start,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             ALUinB,
    output logic             Rdst,
    output logic             Rwd,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);
    state_t state, next_state;
    class_t cls;
    logic   muldiv;
    logic   waiting, expired, tmo, retire, sel_on;

    // Stall = sitting in a wait state with its ready low
    assign waiting = (state == FETCH && !imem_ready) ||
                     (state == EXEC && muldiv && !alu_ready) ||
                     (state == MEM && !dmem_ready);
    assign tmo     = waiting && expired;
    assign retire  = (state == WB) || (state == MEM && cls == SW && dmem_ready);
    assign sel_on  = (state == EXEC) || (state == MEM) || (state == WB);

    // Any non-stall cycle either leaves the state or is a single-cycle state,
    // so clearing on !waiting covers every state change; a timeout also clears
    // because FETCH can time out into itself.
    mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (!waiting || expired),
        .enable  (waiting),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            FETCH:   next_state = imem_ready ? DECODE : (tmo ? FETCH : FETCH);
            DECODE:  next_state = EXEC;
            EXEC:    next_state = waiting ? (tmo ? FETCH : EXEC) :
                                  (cls == ILLEGAL)           ? FETCH :
                                  (cls == LW || cls == SW)   ? MEM   : WB;
            MEM:     next_state = dmem_ready ? ((cls == LW) ? WB : FETCH) :
                                  (tmo ? FETCH : MEM);
            WB:      next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= FETCH;
            cls     <= NOP;
            muldiv  <= 1'b0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                cls    <= decode_class(opcode);
                muldiv <= is_muldiv(opcode, aluop);
            end
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    // Outputs are forced low while resetn is held so the reset cycle is quiet
    assign imem_req  = resetn && state == FETCH;
    assign ir_we     = resetn && state == FETCH && imem_ready;
    assign pc_we     = ir_we;
    assign alu_start = resetn && state == DECODE && is_muldiv(opcode, aluop);
    assign dmem_re   = resetn && state == MEM && cls == LW;
    assign dmem_we   = resetn && state == MEM && cls == SW && !tmo;
    assign rf_we     = resetn && state == WB;
    assign ALUinB    = resetn && sel_on && (cls == ADDI || cls == LW || cls == SW);
    assign Rdst      = resetn && sel_on && cls == RTYPE;
    assign Rwd       = resetn && sel_on && cls == LW;
    assign illegal   = resetn && state == EXEC && cls == ILLEGAL;
    assign timeout   = resetn && tmo;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed-vector scoreboard bench for mc_sequencer (MAX_WAIT=4)
module tb_mc_sequencer;

    localparam logic [11:0] IMQ = 12'h800, IRW = 12'h400, PCW = 12'h200, AST = 12'h100;
    localparam logic [11:0] DRE = 12'h080, DWE = 12'h040, RFW = 12'h020, AIB = 12'h010;
    localparam logic [11:0] RDS = 12'h008, RWD = 12'h004, ILL = 12'h002, TMO = 12'h001;
    localparam logic [11:0] FET = IMQ | IRW | PCW;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [4:0]  opcode = '0, aluop = '0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_ready = 1'b0;
    logic        imem_req, ir_we, pc_we, alu_start, dmem_re, dmem_we, rf_we;
    logic        ALUinB, Rdst, Rwd, illegal, timeout;
    logic [31:0] retired;

    logic [43:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mc_sequencer #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .clock(clock), .resetn(resetn), .opcode(opcode), .aluop(aluop),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_ready(alu_ready),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .alu_start(alu_start),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .rf_we(rf_we), .ALUinB(ALUinB),
        .Rdst(Rdst), .Rwd(Rwd), .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    // Monitor: every cycle the DUT presents a full output vector mid-cycle
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [43:0] e, a;
            e = exp_q.pop_front();
            a = {imem_req, ir_we, pc_we, alu_start, dmem_re, dmem_we, rf_we,
                 ALUinB, Rdst, Rwd, illegal, timeout, retired};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL step%0d: got strobes=%b retired=%0d, want strobes=%b retired=%0d",
                         checks, a[43:32], a[31:0], e[43:32], e[31:0]);
            end
        end
    end

    task automatic step(input logic rn, input logic [4:0] op, input logic [4:0] aop,
                        input logic im, input logic dm, input logic al,
                        input logic [11:0] eb, input logic [31:0] er);
        @(posedge clock);
        #1;
        resetn = rn; opcode = op; aluop = aop;
        imem_ready = im; dmem_ready = dm; alu_ready = al;
        exp_q.push_back({eb, er});
    endtask

    initial begin
        // reset
        step(0, 5'b00000, 5'b00000, 1, 1, 1, 12'h000, 0);
        step(0, 5'b00000, 5'b00000, 1, 1, 1, 12'h000, 0);
        // R-type add, readies tied high
        step(1, 5'b00000, 5'b00000, 1, 1, 1, FET, 0);
        step(1, 5'b00000, 5'b00000, 1, 1, 1, 12'h000, 0);
        step(1, 5'b00000, 5'b00000, 1, 1, 1, RDS, 0);
        step(1, 5'b00000, 5'b00000, 1, 1, 1, RFW | RDS, 0);
        // LW, dmem_ready after 3 stalled cycles
        step(1, 5'b01000, 5'b00000, 1, 0, 0, FET, 1);
        step(1, 5'b01000, 5'b00000, 1, 0, 0, 12'h000, 1);
        step(1, 5'b01000, 5'b00000, 1, 0, 0, AIB | RWD, 1);
        for (int i = 0; i < 3; i++)
            step(1, 5'b01000, 5'b00000, 1, 0, 0, DRE | AIB | RWD, 1);
        step(1, 5'b01000, 5'b00000, 1, 1, 0, DRE | AIB | RWD, 1);
        step(1, 5'b01000, 5'b00000, 1, 0, 0, RFW | AIB | RWD, 1);
        // MULT, alu_ready on 5th EXEC cycle (coincides with count = MAX_WAIT)
        step(1, 5'b00000, 5'b00110, 1, 1, 0, FET, 2);
        step(1, 5'b00000, 5'b00110, 1, 1, 0, AST, 2);
        for (int i = 0; i < 4; i++)
            step(1, 5'b00000, 5'b00110, 1, 1, 0, RDS, 2);
        step(1, 5'b00000, 5'b00110, 1, 1, 1, RDS, 2);
        step(1, 5'b00000, 5'b00110, 1, 1, 0, RFW | RDS, 2);
        // illegal opcode
        step(1, 5'b11111, 5'b00110, 1, 1, 1, FET, 3);
        step(1, 5'b11111, 5'b00110, 1, 1, 1, 12'h000, 3);
        step(1, 5'b11111, 5'b00110, 1, 1, 1, ILL, 3);
        // SW with dmem_ready never: timeout on 5th MEM cycle
        step(1, 5'b00111, 5'b00000, 1, 0, 0, FET, 3);
        step(1, 5'b00111, 5'b00000, 1, 0, 0, 12'h000, 3);
        step(1, 5'b00111, 5'b00000, 1, 0, 0, AIB, 3);
        for (int i = 0; i < 4; i++)
            step(1, 5'b00111, 5'b00000, 1, 0, 0, DWE | AIB, 3);
        step(1, 5'b00111, 5'b00000, 1, 0, 0, TMO | AIB, 3);
        // SW with ready exactly at the timeout boundary: ready wins
        step(1, 5'b00111, 5'b00000, 1, 0, 0, FET, 3);
        step(1, 5'b00111, 5'b00000, 1, 0, 0, 12'h000, 3);
        step(1, 5'b00111, 5'b00000, 1, 0, 0, AIB, 3);
        for (int i = 0; i < 4; i++)
            step(1, 5'b00111, 5'b00000, 1, 0, 0, DWE | AIB, 3);
        step(1, 5'b00111, 5'b00000, 1, 1, 0, DWE | AIB, 3);
        // ADDI with two-cycle fetch stall
        step(1, 5'b00101, 5'b00000, 0, 1, 1, IMQ, 4);
        step(1, 5'b00101, 5'b00000, 0, 1, 1, IMQ, 4);
        step(1, 5'b00101, 5'b00000, 1, 1, 1, FET, 4);
        step(1, 5'b00101, 5'b00000, 1, 1, 1, 12'h000, 4);
        step(1, 5'b00101, 5'b00000, 1, 1, 1, AIB, 4);
        step(1, 5'b00101, 5'b00000, 1, 1, 1, RFW | AIB, 4);
        // fetch timeout, then counter restarts in FETCH
        for (int i = 0; i < 4; i++)
            step(1, 5'b00000, 5'b00000, 0, 0, 0, IMQ, 5);
        step(1, 5'b00000, 5'b00000, 0, 0, 0, IMQ | TMO, 5);
        for (int i = 0; i < 3; i++)
            step(1, 5'b00000, 5'b00000, 0, 0, 0, IMQ, 5);
        // SW interrupted by reset in MEM
        step(1, 5'b00111, 5'b00000, 1, 0, 0, FET, 5);
        step(1, 5'b00111, 5'b00000, 1, 0, 0, 12'h000, 5);
        step(1, 5'b00111, 5'b00000, 1, 0, 0, AIB, 5);
        step(1, 5'b00111, 5'b00000, 1, 0, 0, DWE | AIB, 5);
        step(0, 5'b00111, 5'b00000, 1, 0, 0, 12'h000, 0);
        step(1, 5'b00111, 5'b00000, 0, 0, 0, IMQ, 0);
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the 5-bit-opcode MIPS-subset datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the register, memory and PC write strobes plus the static mux selects ALUinB, Rdst and Rwd.
- Handshakes with instruction memory, data memory and the multi-cycle mult/div ALU.
- Sits between the top-level datapath and its memories; replaces purely combinational decode for multi-cycle builds.

Parameters:
MAX_WAIT, 16, cycles any wait state may stall before timeout (>=2)
CNT_W, 32, width of retired-instruction counter

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
opcode  input  5  IR[31:27], valid from DECODE onward
aluop  input  5  IR[6:2], meaningful for R-type only
imem_ready  input  1  instruction word valid this cycle
dmem_ready  input  1  data memory access complete this cycle
alu_ready  input  1  mult/div result valid this cycle
imem_req  output  1  fetch request
ir_we  output  1  latch instruction register
pc_we  output  1  PC <= PC+1
alu_start  output  1  one-cycle mult/div start pulse
dmem_re  output  1  data memory read request
dmem_we  output  1  data memory write enable
rf_we  output  1  register file write enable
ALUinB  output  1  ALU B operand = immediate
Rdst  output  1  write dest = rd (R-type)
Rwd  output  1  writeback data from memory
illegal  output  1  one-cycle pulse, unsupported opcode
timeout  output  1  one-cycle pulse, wait exceeded MAX_WAIT
retired  output  CNT_W  count of completed instructions

Behaviour:
Reset:
- Asynchronous on resetn low: state=FETCH; class register=NOP; wait counter=0; retired=0; all strobes/selects/pulses 0.
- Reset mid-instruction abandons it; no strobe is asserted in the reset cycle.

Decode classes, captured into a register in DECODE:
- R-type = 00000
- ADDI = 00101
- SW = 00111
- LW = 01000
- all other opcodes = ILLEGAL
- MULDIV: R-type with aluop 00110 (mult) or 00111 (div).

Outputs:
- Strobes are combinational from state, class and ready inputs.
- ALUinB = class in {ADDI, LW, SW}; Rdst = R-type; Rwd = LW.
- The three selects are driven from the class register in EXEC/MEM/WB and are 0 in FETCH/DECODE.

States:
- FETCH: imem_req=1. On imem_ready: ir_we=1, pc_we=1, go DECODE. Otherwise stay.
- DECODE: one cycle; load class register. alu_start=1 iff MULDIV. Go EXEC.
- EXEC:
  - MULDIV: stay until alu_ready.
  - Others: one cycle.
  - Exit: LW/SW -> MEM; R-type/ADDI -> WB; ILLEGAL -> illegal=1, go FETCH, no retire.
- MEM:
  - LW: dmem_re=1 held; on dmem_ready go WB.
  - SW: dmem_we=1 held; on dmem_ready retire, go FETCH.
- WB: rf_we=1 for exactly one cycle; retire; go FETCH.

Wait counter:
- Counts consecutive stalled cycles in FETCH, EXEC(MULDIV) and MEM.
- Clears on every state change.
- When the count reaches MAX_WAIT with ready still low: timeout=1, go FETCH, no retire, no pc_we; rf_we and dmem_we stay 0 that cycle.
- A ready that coincides with the counter reaching MAX_WAIT wins: normal exit, no timeout.

Counters and pulses:
- retired increments by 1 on each retire and wraps modulo 2^CNT_W.
- illegal and timeout never assert together.

Latency with zero-wait memories:
- R-type/ADDI/SW: 4 cycles.
- LW: 5 cycles.
- MULDIV: 4 + (cycles until alu_ready).

Decomposition:
- Package mc_ctrl_pkg: opcode constants OP_RTYPE/OP_ADDI/OP_SW/OP_LW; aluop constants ALU_MULT/ALU_DIV; state enum {FETCH, DECODE, EXEC, MEM, WB}; class enum {NOP, RTYPE, ADDI, SW, LW, ILLEGAL}.
- One sub-module, mc_wait_timer: clear/enable inputs, expired output, parameterised by MAX_WAIT.

Test Plan:
- Reset then R-type add (00000, aluop 00000), readies tied 1 -> ir_we/pc_we cycle 1, rf_we cycle 4 with Rdst=1, ALUinB=0; retired=1.
- LW with dmem_ready delayed 3 cycles -> dmem_re held 4 cycles, then rf_we one cycle with Rwd=1, ALUinB=1; total 8 cycles; retired+1.
- MULT (aluop 00110), alu_ready after 5 cycles -> alu_start pulse in DECODE only, WB one cycle after alu_ready; no dmem strobes.
- Opcode 11111 -> illegal pulse in EXEC, no rf_we/dmem_we, retired unchanged, next cycle imem_req=1.
- MAX_WAIT=4, SW with dmem_ready never -> dmem_we held 4 cycles, timeout pulse, return to FETCH, retired unchanged; second run with ready on the 4th stalled cycle -> no timeout, retired+1.
- resetn low for one cycle mid-MEM of SW -> dmem_we drops immediately, state FETCH, retired=0.
